// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encoding, score widths,
// point values and the saturating score adder.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_BOSS  = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  localparam int SCORE_W       = 14;
  localparam int SCORE_MAX_DEF = 9999;

  localparam logic [SCORE_W-1:0] EP_POINTS   = 14'd1;
  localparam logic [SCORE_W-1:0] BOSS_POINTS = 14'd10;

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [SCORE_W-1:0] inc,
    input logic [SCORE_W-1:0] max_val
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_ctrl_tick_timer.sv
// Tick-enabled modulo-TICKS counter; tc flags the tick on which it wraps.
module tick_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count_reg;

  assign tc = en & ~clr & (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM: start screen, board clear, normal play, boss fight
// and the timed win/lose screen, with a saturating score.
module game_ctrl
  import game_pkg::*;
#(
  parameter int KILLS_FOR_BOSS = 10,
  parameter int SPAWN_TICKS    = 150,
  parameter int OVER_TICKS     = 300,
  parameter int SCORE_MAX      = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               ep_boom,
  input  logic               b_boom,
  input  logic               p_boom,
  output logic               play_en,
  output logic               obj_rst,
  output logic               spawn_req,
  output logic               boss_phase,
  output logic               win,
  output logic               lose,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state
);

  localparam int KW = $clog2(KILLS_FOR_BOSS + 1);
  localparam logic [KW-1:0]      KILLS_LIM = KW'(KILLS_FOR_BOSS);
  localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_MAX);

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [KW-1:0]      kills_reg, kills_next;
  logic               start_q_reg;
  logic               armed_reg;
  logic               spawn_reg;
  logic               start_edge;
  logic               in_play, in_over;
  logic               spawn_tc, over_tc;

  assign in_play = (state_reg == ST_PLAY);
  assign in_over = (state_reg == ST_WIN) || (state_reg == ST_LOSE);

  // armed_reg stays low until start has been seen low after reset, so a key
  // held through reset release never counts as a press.
  assign start_edge = start & ~start_q_reg & armed_reg;

  tick_timer #(.TICKS(SPAWN_TICKS)) u_spawn_timer (
    .clk (clk),
    .rst (rst),
    .clr (~in_play),
    .en  (tick),
    .tc  (spawn_tc)
  );

  tick_timer #(.TICKS(OVER_TICKS)) u_over_timer (
    .clk (clk),
    .rst (rst),
    .clr (~in_over),
    .en  (tick),
    .tc  (over_tc)
  );

  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    kills_next = kills_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_edge) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (ep_boom) begin
          score_next = sat_add(score_reg, EP_POINTS, SCORE_LIM);
          if (kills_reg != KILLS_LIM) kills_next = kills_reg + KW'(1);
        end
        if (p_boom) state_next = ST_LOSE;
        else if (kills_reg == KILLS_LIM) state_next = ST_BOSS;
      end
      ST_BOSS: begin
        if (p_boom) begin
          state_next = ST_LOSE;
        end else if (b_boom) begin
          score_next = sat_add(score_reg, BOSS_POINTS, SCORE_LIM);
          state_next = ST_WIN;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_edge) state_next = ST_CLEAR;
        else if (over_tc) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Entering CLEAR wipes the previous game so the clear cycle already shows 0.
    if (state_next == ST_CLEAR) begin
      score_next = '0;
      kills_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      score_reg   <= '0;
      kills_reg   <= '0;
      start_q_reg <= 1'b0;
      armed_reg   <= 1'b0;
      spawn_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      score_reg   <= score_next;
      kills_reg   <= kills_next;
      start_q_reg <= start;
      armed_reg   <= armed_reg | ~start;
      spawn_reg   <= spawn_tc & (state_next == ST_PLAY);
    end
  end

  assign state      = state_reg;
  assign play_en    = (state_reg == ST_CLEAR) || in_play || (state_reg == ST_BOSS);
  assign obj_rst    = (state_reg == ST_CLEAR);
  assign spawn_req  = spawn_reg;
  assign boss_phase = (state_reg == ST_BOSS);
  assign win        = (state_reg == ST_WIN);
  assign lose       = (state_reg == ST_LOSE);
  assign score      = score_reg;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter KILLS_FOR_BOSS, default 10; enemy kills in PLAY that trigger the boss phase.
REQ-002 Parameter SPAWN_TICKS, default 150; ticks between enemy spawn requests.
REQ-003 Parameter OVER_TICKS, default 300; ticks the WIN/LOSE screen is held before IDLE.
REQ-004 Parameter SCORE_MAX, default 9999; score saturation value.
REQ-005 clk  in  1  system clock; one clock domain; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  Enter key level from the keyboard decoder.
REQ-008 tick  in  1  movement-rate enable, one clk cycle wide.
REQ-009 ep_boom  in  1  enemy destroyed, one-cycle pulse.
REQ-010 b_boom  in  1  boss destroyed, one-cycle pulse.
REQ-011 p_boom  in  1  player destroyed, one-cycle pulse.
REQ-012 play_en  out  1  high in CLEAR, PLAY, BOSS; selects game layers over the start screen.
REQ-013 obj_rst  out  1  one-cycle pulse clearing planes, bullets and health for a new game.
REQ-014 spawn_req  out  1  one-cycle enemy spawn request.
REQ-015 boss_phase  out  1  high in BOSS only; enables the boss and its bullets.
REQ-016 win, lose  out  1 each  high in WIN / LOSE respectively.
REQ-017 score  out  14  binary score to the score display.
REQ-018 state  out  3  encoded state: IDLE=0, CLEAR=1, PLAY=2, BOSS=3, WIN=4, LOSE=5.

Function
REQ-019 start SHALL be edge-detected against a registered copy; only a 0->1 transition counts as start_edge.
REQ-020 IDLE: start_edge -> CLEAR; all event inputs ignored.
REQ-021 CLEAR SHALL last exactly one cycle with obj_rst=1, zero score, kill count and timers, then go to PLAY.
REQ-022 PLAY: ep_boom increments kill count and adds 1 to score; kill count reaching KILLS_FOR_BOSS -> BOSS on the next cycle.
REQ-023 PLAY: spawn timer counts ticks; on the tick where it reaches SPAWN_TICKS-1 it wraps to 0 and asserts spawn_req that cycle.
REQ-024 spawn_req SHALL never be asserted outside PLAY; the spawn timer holds at 0 outside PLAY.
REQ-025 BOSS: b_boom adds 10 to score -> WIN; ep_boom ignored.
REQ-026 PLAY or BOSS: p_boom -> LOSE; p_boom takes precedence over a simultaneous kill transition or b_boom, but a same-cycle ep_boom still scores.
REQ-027 Score addition SHALL saturate at SCORE_MAX; it never wraps.
REQ-028 WIN/LOSE: over timer counts ticks; reaching OVER_TICKS-1 -> IDLE; start_edge earlier -> CLEAR.
REQ-029 score SHALL hold its value through WIN, LOSE and IDLE until the next CLEAR.
REQ-030 All outputs SHALL be registered or decoded from registered state; no combinational path from inputs to outputs.
REQ-031 Encodings 6 and 7 SHALL return to IDLE on the next cycle.

Reset
REQ-032 On rst: state=IDLE, play_en=0, obj_rst=0, spawn_req=0, boss_phase=0, win=0, lose=0, score=0, counters=0, start edge register=0.
REQ-033 rst asserted mid-game SHALL abort to IDLE within one cycle; a start held high through reset release SHALL NOT produce start_edge.

Structure
REQ-034 A shared package game_pkg SHALL hold the state encoding, score increments (1 and 10) and the SCORE_MAX default.
REQ-035 One sub-module, tick_timer (tick-enabled counter with terminal-count pulse and clear), SHALL be instantiated for the spawn and over timers.

Verification
REQ-036 rst, then start 0->1 -> obj_rst pulse one cycle later, state 1 then 2, play_en=1.
REQ-037 SPAWN_TICKS=4 in PLAY, tick every cycle -> spawn_req on ticks 4, 8, 12; none after moving to BOSS.
REQ-038 10 ep_boom pulses in PLAY -> score=10, BOSS entered; then b_boom -> score=20, win=1.
REQ-039 ep_boom and p_boom in the same cycle in PLAY -> score+1, state=LOSE, no BOSS entry.
REQ-040 score preset near 9995 and b_boom -> score=9999; further events leave it unchanged.
REQ-041 LOSE with OVER_TICKS=3 -> IDLE after 3 ticks; start held high through rst -> stays IDLE.
